cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the Common Data Bus (CDB) between the functional units that finish Tomasulo instructions, such as the ADD1/ADD2 reservation-station adders and a multiplier.
- Picks one completing requester per cycle using round-robin priority, then broadcasts that requester's reservation-station tag and result to the register status table and all reservation stations.
- Sits between the functional-unit outputs and the Qi/Qj/Qk wake-up logic fed by the dispatch unit.

Parameters:
- N_REQ, 3, number of requesting functional units (index 0 = ADD1, 1 = ADD2, 2 = MUL).
- TAG_W, 3, reservation-station tag width; matches the Qi/Qj/Qk encoding.
- DATA_W, 16, result width.
- NO_TAG, 3'd0, tag value meaning "free register / no station"; never valid on the CDB.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- Req  in  N_REQ  per-unit request; bit i high means unit i holds a completed result.
- Req_Tag  in  N_REQ*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- Req_Data  in  N_REQ*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- Cdb_Hold  in  1  consumer back-pressure; when high, the current broadcast is frozen.
- Grant  out  N_REQ  one-hot, registered; bit i high for exactly the cycle unit i's result is on the CDB.
- Cdb_Valid  out  1  CDB carries a valid broadcast this cycle.
- Cdb_Tag  out  TAG_W  tag being broadcast.
- Cdb_Data  out  DATA_W  result being broadcast.
- Tag_Err  out  1  sticky flag; set when a requesting unit presents Req_Tag == NO_TAG.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (Reset==0 at a rising edge) forces Grant=0, Cdb_Valid=0, Cdb_Tag=NO_TAG, Cdb_Data=16'hFFF0, Tag_Err=0, Last_Grant=N_REQ-1 and Prev_Grant=0.
  - Reset is not deferred: it overrides a broadcast or hold in progress.
  - Cdb_Data=16'hFFF0 is the team's "no value" pattern.
- Internal state:
  - Last_Grant: round-robin pointer, ceil(log2 N_REQ) bits.
  - Prev_Grant: N_REQ-bit mask of the requester granted on the previous edge.
- Eligible set each edge: Elig = Req & ~Prev_Grant & {tag_i != NO_TAG}.
  - Prev_Grant masks a requester whose Req is still stale from its last grant, so one unit is never granted on two consecutive cycles.
- State BCAST_IDLE/BCAST_ACTIVE is encoded by Cdb_Valid. On each edge with Reset==1:
  - Cdb_Hold==1 and Cdb_Valid==1: all outputs, Last_Grant and Prev_Grant hold; Grant is forced to 0. The winner saw Grant on the first cycle only, so it is not granted twice.
  - Cdb_Hold==1 and Cdb_Valid==0: no new grant is issued; outputs stay idle.
  - Cdb_Hold==0 and Elig != 0: the winner is the first set bit of Elig, searching from (Last_Grant+1) mod N_REQ upward with wrap-around. Then:
    - Grant is one-hot on the winner; Cdb_Valid=1.
    - Cdb_Tag and Cdb_Data take the winner's slices.
    - Last_Grant and Prev_Grant are updated to the winner.
  - Cdb_Hold==0 and Elig == 0: Grant=0, Cdb_Valid=0, Cdb_Tag=NO_TAG, Cdb_Data=16'hFFF0, Prev_Grant=0.
- Latency: a Req sampled high at edge k (and eligible) appears on the CDB in cycle k..k+1 when it wins. Worst-case wait with all units requesting continuously is N_REQ-1 broadcast cycles.
- Requester contract:
  - Hold Req, Req_Tag and Req_Data stable until Grant is seen.
  - On the edge after Grant, drop Req or present the next result.
- Tag_Err is set at any edge where Req[i]==1 and tag_i==NO_TAG. That request is never granted. Tag_Err clears only on reset.
- Width rules: tags and data pass through unmodified; no arithmetic on the datapath. The pointer increment wraps modulo N_REQ; N_REQ need not be a power of two.
- Simultaneous events:
  - Cdb_Hold takes priority over new requests.
  - A request arriving during a hold is arbitrated on the first edge after Cdb_Hold falls.

Test Plan:
- Reset low for 2 edges during an active broadcast -> Grant=000, Cdb_Valid=0, Cdb_Tag=0, Cdb_Data=16'hFFF0, Tag_Err=0.
- Req=010, tag1=3'd2, data1=16'h1234 held until Grant -> the following cycle has Grant=010, Cdb_Valid=1, Cdb_Tag=2, Cdb_Data=16'h1234; the next cycle (Req still high) has Grant=000.
- Req=111 held continuously with tags 1,2,3 -> grant order 001,010,100,001,...; each tag appears once per 3 broadcasts.
- Grant to unit 0 then Cdb_Hold=1 for 3 cycles with Req=110 -> outputs frozen on unit 0's tag/data with Grant=000; after release, unit 1 is granted on the next edge.
- Req=001 with tag0=3'd0 -> no grant, Cdb_Valid=0, Tag_Err=1 and remains 1 until reset.
- Req=101 with unit 0 just granted (Last_Grant=0) -> unit 2 granted next; then unit 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter for Tomasulo completion
// One functional-unit result per cycle wins the CDB; back-pressure freezes the broadcast.
module cdb_arbiter #(
   parameter int               N_REQ  = 3,
   parameter int               TAG_W  = 3,
   parameter int               DATA_W = 16,
   parameter logic [TAG_W-1:0] NO_TAG = '0
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [N_REQ-1:0]        Req,
   input  logic [N_REQ*TAG_W-1:0]  Req_Tag,
   input  logic [N_REQ*DATA_W-1:0] Req_Data,
   input  logic                    Cdb_Hold,
   output logic [N_REQ-1:0]        Grant,
   output logic                    Cdb_Valid,
   output logic [TAG_W-1:0]        Cdb_Tag,
   output logic [DATA_W-1:0]       Cdb_Data,
   output logic                    Tag_Err
);

   localparam int                PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [DATA_W-1:0] NO_DATA  = DATA_W'(16'hFFF0);
   localparam logic [PTR_W-1:0]  LAST_RST = PTR_W'(N_REQ - 1);

   logic [PTR_W-1:0]  last_grant, last_grant_nxt;
   logic [N_REQ-1:0]  prev_grant, prev_grant_nxt;
   logic [N_REQ-1:0]  tag_ok, elig, grant_nxt;
   logic              valid_nxt, tag_err_nxt, win_found;
   logic [TAG_W-1:0]  tag_nxt;
   logic [DATA_W-1:0] data_nxt;
   int                win_idx, cand;

   always_comb begin : tag_check
      tag_ok = '0;
      for (int i = 0; i < N_REQ; i++) begin
         tag_ok[i] = (Req_Tag[i*TAG_W +: TAG_W] != NO_TAG);
      end
   end

   // prev_grant masks a stale Req from the unit that just won.
   assign elig = Req & ~prev_grant & tag_ok;

   always_comb begin : rr_search
      win_found = 1'b0;
      win_idx   = 0;
      cand      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last_grant) + k) % N_REQ;
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin : next_state
      grant_nxt      = '0;
      valid_nxt      = Cdb_Valid;
      tag_nxt        = Cdb_Tag;
      data_nxt       = Cdb_Data;
      last_grant_nxt = last_grant;
      prev_grant_nxt = prev_grant;
      tag_err_nxt    = Tag_Err | (|(Req & ~tag_ok));
      if (!Cdb_Hold) begin
         if (win_found) begin
            grant_nxt          = '0;
            grant_nxt[win_idx] = 1'b1;
            valid_nxt          = 1'b1;
            tag_nxt            = Req_Tag[win_idx*TAG_W +: TAG_W];
            data_nxt           = Req_Data[win_idx*DATA_W +: DATA_W];
            last_grant_nxt     = PTR_W'(win_idx);
            prev_grant_nxt     = grant_nxt;
         end else begin
            valid_nxt      = 1'b0;
            tag_nxt        = NO_TAG;
            data_nxt       = NO_DATA;
            prev_grant_nxt = '0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         Grant      <= '0;
         Cdb_Valid  <= 1'b0;
         Cdb_Tag    <= NO_TAG;
         Cdb_Data   <= NO_DATA;
         Tag_Err    <= 1'b0;
         last_grant <= LAST_RST;
         prev_grant <= '0;
      end else begin
         Grant      <= grant_nxt;
         Cdb_Valid  <= valid_nxt;
         Cdb_Tag    <= tag_nxt;
         Cdb_Data   <= data_nxt;
         Tag_Err    <= tag_err_nxt;
         last_grant <= last_grant_nxt;
         prev_grant <= prev_grant_nxt;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a reference model
module tb_cdb_arbiter;

   localparam int N = 3;

   logic        Clock;
   logic        Reset;
   logic [2:0]  Req;
   logic [8:0]  Req_Tag;
   logic [47:0] Req_Data;
   logic        Cdb_Hold;
   logic [2:0]  Grant;
   logic        Cdb_Valid;
   logic [2:0]  Cdb_Tag;
   logic [15:0] Cdb_Data;
   logic        Tag_Err;

   logic [2:0]  tg [3];
   logic [15:0] dt [3];

   assign Req_Tag  = {tg[2], tg[1], tg[0]};
   assign Req_Data = {dt[2], dt[1], dt[0]};

   cdb_arbiter dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Req      (Req),
      .Req_Tag  (Req_Tag),
      .Req_Data (Req_Data),
      .Cdb_Hold (Cdb_Hold),
      .Grant    (Grant),
      .Cdb_Valid(Cdb_Valid),
      .Cdb_Tag  (Cdb_Tag),
      .Cdb_Data (Cdb_Data),
      .Tag_Err  (Tag_Err)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: winner index, broadcast contents and pointer as plain integers
   int          m_win;
   logic        m_valid;
   logic [2:0]  m_tag;
   logic [15:0] m_data;
   logic        m_err;
   int          m_last;
   int          m_prev;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int w;
      if (!Reset) begin
         m_win = -1; m_valid = 0; m_tag = 0; m_data = 16'hFFF0;
         m_err = 0; m_last = N - 1; m_prev = -1;
      end else begin
         for (int i = 0; i < N; i++) if (Req[i] && tg[i] == 0) m_err = 1;
         if (Cdb_Hold) begin
            m_win = -1;
         end else begin
            w = -1;
            for (int off = 1; off <= N; off++) begin
               int c;
               c = (m_last + off) % N;
               if (w < 0 && Req[c] && c != m_prev && tg[c] != 0) w = c;
            end
            m_win = w;
            if (w >= 0) begin
               m_valid = 1; m_tag = tg[w]; m_data = dt[w]; m_last = w; m_prev = w;
            end else begin
               m_valid = 0; m_tag = 0; m_data = 16'hFFF0; m_prev = -1;
            end
         end
      end
   endtask

   task automatic step();
      logic [2:0] exp_grant;
      @(posedge Clock);
      model_edge();
      #1;
      exp_grant = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
      check("grant", 32'(Grant), 32'(exp_grant));
      check("valid", 32'(Cdb_Valid), 32'(m_valid));
      check("tag", 32'(Cdb_Tag), 32'(m_tag));
      check("data", 32'(Cdb_Data), 32'(m_data));
      check("tag_err", 32'(Tag_Err), 32'(m_err));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_grant"}, 32'(Grant), 32'h0);
      check({tag, "_valid"}, 32'(Cdb_Valid), 32'h0);
      check({tag, "_tag"}, 32'(Cdb_Tag), 32'h0);
      check({tag, "_data"}, 32'(Cdb_Data), 32'hFFF0);
      check({tag, "_err"}, 32'(Tag_Err), 32'h0);
   endtask

   initial begin
      Reset = 1'b0; Cdb_Hold = 1'b0; Req = 3'b000;
      tg[0] = 3'd1; tg[1] = 3'd2; tg[2] = 3'd3;
      dt[0] = 16'hA0A0; dt[1] = 16'h1234; dt[2] = 16'hC3C3;
      step(); step();
      check_reset_state("por");

      // single requester, stale Req masked on the following cycle
      Reset = 1'b1; Req = 3'b010;
      step();
      check("single_grant", 32'(Grant), 32'h2);
      check("single_tag", 32'(Cdb_Tag), 32'h2);
      check("single_data", 32'(Cdb_Data), 32'h1234);
      step();
      check("single_stale", 32'(Grant), 32'h0);
      Req = 3'b000;
      step();

      // all requesting continuously from reset: strict rotation
      Reset = 1'b0; step(); Reset = 1'b1;
      Req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         step();
         check("rr_order", 32'(Grant), 32'(3'b001 << (k % 3)));
         check("rr_tag", 32'(Cdb_Tag), 32'((k % 3) + 1));
      end

      // hold freezes unit 0's broadcast, unit 1 wins on release
      Req = 3'b000; Reset = 1'b0; step(); Reset = 1'b1;
      Req = 3'b001; step();
      check("hold_pre", 32'(Grant), 32'h1);
      Req = 3'b110; Cdb_Hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_grant", 32'(Grant), 32'h0);
         check("hold_valid", 32'(Cdb_Valid), 32'h1);
         check("hold_data", 32'(Cdb_Data), 32'hA0A0);
      end
      Cdb_Hold = 1'b0; step();
      check("hold_release", 32'(Grant), 32'h2);

      // unit 0 just granted, Req=101 -> unit 2 then unit 0
      Req = 3'b000; Reset = 1'b0; step(); Reset = 1'b1;
      Req = 3'b001; step();
      Req = 3'b101; step();
      check("wrap_u2", 32'(Grant), 32'h4);
      step();
      check("wrap_u0", 32'(Grant), 32'h1);

      // NO_TAG request: never granted, sticky error
      Req = 3'b000; Reset = 1'b0; step(); Reset = 1'b1;
      tg[0] = 3'd0; Req = 3'b001; step();
      check("notag_grant", 32'(Grant), 32'h0);
      check("notag_err", 32'(Tag_Err), 32'h1);
      Req = 3'b000; step(); step();
      check("notag_sticky", 32'(Tag_Err), 32'h1);
      tg[0] = 3'd5; Req = 3'b001; step();
      check("notag_bcast", 32'(Cdb_Valid), 32'h1);
      Reset = 1'b0; step(); step();
      check_reset_state("rst_active");
      Reset = 1'b1; Req = 3'b000;

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         Reset    = ($urandom_range(0, 63) != 0);
         Cdb_Hold = ($urandom_range(0, 3) == 0);
         Req      = 3'($urandom);
         for (int i = 0; i < N; i++) begin
            tg[i] = 3'($urandom);
            dt[i] = 16'($urandom);
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
